line_buffer_window: RTL
=======================

LINE_BUFFER_WINDOW -- requirements
Module: line_buffer_window

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 16, pixel bit width.
REQ-002 SHALL have parameter NKX, default 3, kernel width in pixels.
REQ-003 SHALL have parameter NKY, default 3, kernel height in pixels.
REQ-004 SHALL have parameter IMG_W, default 32, frame width in pixels, with IMG_W >= NKX.
REQ-005 SHALL have parameter IMG_H, default 32, frame height in pixels, with IMG_H >= NKY.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clear, input, 1, synchronous frame abort.
REQ-009 SHALL have port in_valid, input, 1, raster pixel valid.
REQ-010 SHALL have port in_ready, output, 1, pixel accepted when in_valid && in_ready.
REQ-011 SHALL have port in_pixel, input, PIX_WIDTH, raster-order pixel (row-major, top-left first).
REQ-012 SHALL have port win_valid, output, 1, window held on pixel_data_flat.
REQ-013 SHALL have port win_ready, input, 1, downstream consumes window when win_valid && win_ready.
REQ-014 SHALL have port pixel_data_flat, output, NKX*NKY*PIX_WIDTH, window feeding the MAC array pixel port.
REQ-015 SHALL have port win_row, output, clog2(IMG_H), output-pixel row of the held window.
REQ-016 SHALL have port win_col, output, clog2(IMG_W), output-pixel column of the held window.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse after last frame pixel accepted.

Function
REQ-018 Tap k = r*NKX + c SHALL occupy pixel_data_flat[k*PIX_WIDTH +: PIX_WIDTH]; r=0 is the top (oldest) row and c=0 the leftmost (oldest) column, matching weight tap order.
REQ-019 Valid-mode convolution, no padding: a window SHALL be emitted only when the accepted pixel has row >= NKY-1 and col >= NKX-1.
REQ-020 Each frame SHALL emit exactly (IMG_W-NKX+1)*(IMG_H-NKY+1) windows.
REQ-021 Latency: a window completed by a pixel accepted in cycle t SHALL appear with win_valid=1 in cycle t+1.
REQ-022 win_row/win_col SHALL equal the accepted pixel's row-(NKY-1) and col-(NKX-1).
REQ-023 Single output register: in_ready SHALL be (state != S_DONE) && (!win_valid || win_ready).
REQ-024 While win_valid && !win_ready, pixel_data_flat, win_row and win_col SHALL hold stable.
REQ-025 NKY-1 line memories SHALL store the previous rows; each accept reads column col before writing in_pixel (read-before-write).
REQ-026 Column counter SHALL wrap IMG_W-1 -> 0 and increment the row counter; row wraps IMG_H-1 -> 0 at frame end.
REQ-027 The window shift register SHALL shift left on every accept, including non-emitting pixels, so horizontal history is continuous; its content at col < NKX-1 is don't-care and never emitted.
REQ-028 FSM S_FILL (row < NKY-1) -> S_STREAM when row reaches NKY-1; S_STREAM -> S_DONE on accept of pixel (IMG_H-1, IMG_W-1); S_DONE -> S_FILL after one cycle.
REQ-029 In S_DONE, frame_done SHALL be 1 for exactly that cycle, in_ready SHALL be 0, and counters SHALL reset to 0.
REQ-030 clear SHALL return the FSM to S_FILL, zero the counters, drop win_valid, and suppress frame_done; clear wins over a simultaneous accept.
REQ-031 Line memory contents SHALL not be cleared; stale data is overwritten before use by construction.

Reset
REQ-032 On rst=0: state=S_FILL, counters=0, win_valid=0, frame_done=0, pixel_data_flat=0, win_row=0, win_col=0; in_ready=1 after release.

Structure
REQ-033 PIX_WIDTH, NKX, NKY defaults, the FSM state encoding and a tap-index function SHALL live in the shared package conv_pkg.
REQ-034 Line storage SHALL be one sub-module line_ram (depth IMG_W, width PIX_WIDTH, one read-before-write port), instantiated NKY-1 times.

Verification
REQ-035 IMG_W=5, IMG_H=4, pixel=row*16+col, win_ready=1 -> 6 windows; first window taps 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22 at win_row=0, win_col=0.
REQ-036 Same frame, last window -> taps 0x12,0x13,0x14,0x22,0x23,0x24,0x32,0x33,0x34 at (1,2); frame_done pulses once, 1 cycle after the accept of 0x34.
REQ-037 Random win_ready at 30% duty -> same 6 windows in order, none lost or duplicated, outputs stable while stalled.
REQ-038 Two back-to-back frames with constant in_valid -> 12 windows; second frame's first window is identical to the first frame's, with no leakage of stale rows.
REQ-039 clear asserted after 7 pixels, then a full frame -> no window emitted before the clear frame completes, no frame_done for the aborted frame, and 6 correct windows afterwards.
REQ-040 rst asserted mid-frame while win_valid=1 -> all outputs zero immediately (asynchronously); the next frame produces correct output.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults, FSM encoding and tap ordering for the convolution window datapath.
package conv_pkg;

  localparam int unsigned PIX_WIDTH_DEF = 16;
  localparam int unsigned NKX_DEF       = 3;
  localparam int unsigned NKY_DEF       = 3;

  typedef enum logic [1:0] {
    S_FILL,
    S_STREAM,
    S_DONE
  } state_e;

  // Row-major tap index: r=0 is the oldest row, c=0 the oldest column.
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned nkx);
    return r * nkx + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One image line of pixel storage: asynchronous read, synchronous write, read-before-write.
module line_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; every location is rewritten before it is read for a window.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/line_buffer_window.sv
// Raster-scan line buffer producing NKXxNKY valid-mode convolution windows with
// a single registered output stage and ready/valid handshakes on both sides.
module line_buffer_window
  import conv_pkg::*;
#(
  parameter int unsigned PIX_WIDTH = PIX_WIDTH_DEF,
  parameter int unsigned NKX       = NKX_DEF,
  parameter int unsigned NKY       = NKY_DEF,
  parameter int unsigned IMG_W     = 32,
  parameter int unsigned IMG_H     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PIX_WIDTH-1:0]             in_pixel,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [NKX*NKY*PIX_WIDTH-1:0]     pixel_data_flat,
  output logic [$clog2(IMG_H)-1:0]         win_row,
  output logic [$clog2(IMG_W)-1:0]         win_col,
  output logic                             frame_done
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned WW = NKX * NKY * PIX_WIDTH;

  localparam logic [RW-1:0] RowFirst = RW'(NKY - 1);
  localparam logic [RW-1:0] RowLast  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColFirst = CW'(NKX - 1);
  localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);

  state_e                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic [WW-1:0]          sh_q, sh_d;
  logic [WW-1:0]          data_q, data_d;
  logic                   valid_q, valid_d;
  logic [RW-1:0]          wrow_q, wrow_d;
  logic [CW-1:0]          wcol_q, wcol_d;

  logic                   accept;
  logic                   emit;
  logic [PIX_WIDTH-1:0]   rd   [NKY-1];
  logic [PIX_WIDTH-1:0]   wd   [NKY-1];
  logic [PIX_WIDTH-1:0]   colv [NKY];

  assign in_ready   = (state_q != S_DONE) && (!valid_q || win_ready);
  assign accept     = in_valid && in_ready;
  assign emit       = accept && (row_q >= RowFirst) && (col_q >= ColFirst);
  assign frame_done = (state_q == S_DONE) && !clear;

  // Line j holds row (current-1-j); each accept pushes the column one line further up.
  for (genvar j = 0; j < NKY - 1; j++) begin : g_line
    line_ram #(
      .DEPTH(IMG_W),
      .WIDTH(PIX_WIDTH)
    ) u_line (
      .clk  (clk),
      .we   (accept),
      .addr (col_q),
      .wdata(wd[j]),
      .rdata(rd[j])
    );
  end

  always_comb begin
    wd[0] = in_pixel;
    for (int unsigned j = 1; j < NKY - 1; j++) wd[j] = rd[j-1];
    for (int unsigned r = 0; r < NKY - 1; r++) colv[r] = rd[NKY-2-r];
    colv[NKY-1] = in_pixel;
  end

  // Shift on every accept so horizontal history stays continuous across non-emitting pixels.
  always_comb begin
    sh_d = sh_q;
    if (accept) begin
      for (int unsigned r = 0; r < NKY; r++) begin
        for (int unsigned c = 0; c < NKX; c++) begin
          if (c == NKX - 1) begin
            sh_d[tap_idx(r, c, NKX)*PIX_WIDTH +: PIX_WIDTH] = colv[r];
          end else begin
            sh_d[tap_idx(r, c, NKX)*PIX_WIDTH +: PIX_WIDTH] =
              sh_q[tap_idx(r, c + 1, NKX)*PIX_WIDTH +: PIX_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      S_FILL, S_STREAM: begin
        if (accept) begin
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + 1'b1;
              if (row_d == RowFirst) state_d = S_STREAM;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_FILL;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = S_FILL;
    endcase
    if (clear) begin
      state_d = S_FILL;
      row_d   = '0;
      col_d   = '0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    if (valid_q && win_ready) valid_d = 1'b0;
    if (emit) begin
      valid_d = 1'b1;
      data_d  = sh_d;
      wrow_d  = row_q - RowFirst;
      wcol_d  = col_q - ColFirst;
    end
    if (clear) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FILL;
      row_q   <= '0;
      col_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
    end
  end

  assign win_valid       = valid_q;
  assign pixel_data_flat = data_q;
  assign win_row         = wrow_q;
  assign win_col         = wcol_q;

endmodule
